sprite_load_scheduler: RTL and testbench
========================================

// Module: sprite_load_scheduler
// PURPOSE
//  Shares the single sprite bitmap ROM between NUM_SPRITES sprite_renderer
//  instances during horizontal blank. Replaces the fixed per-renderer
//  "hpos == constant" load strobes.
//  Each scanline it snapshots which renderers are drawing and drives the shared
//  ROM row address for each in turn. It then pulses that renderer's load input.
//  Rotating priority keeps service fair when the blank window is too short;
//  unserved loads are counted per frame.
// PARAMETERS
//  NUM_SPRITES  2    renderers sharing the ROM (1..16)
//  YOFS_BITS    4    width of the ROM row address
//  LOAD_START   256  hpos at which the request snapshot is taken
//  LOAD_END     300  first hpos at which no LOAD cycle may occur
// PORTS
//  clk          in   1                     pixel clock
//  reset        in   1                     asynchronous, active-low reset
//  hpos         in   9                     horizontal counter from hvsync_generator
//  vsync        in   1                     vertical sync from hvsync_generator
//  req          in   NUM_SPRITES           renderer in_progress flags
//  rom_addr_in  in   NUM_SPRITES*YOFS_BITS renderer rom_addr outputs; sprite i at [i*YOFS_BITS +: YOFS_BITS]
//  rom_addr     out  YOFS_BITS             shared ROM row address
//  load         out  NUM_SPRITES           one-hot, 1-cycle load strobes to renderers
//  busy         out  1                     high in SETUP/LOAD
//  frame_drops  out  8                     drops in last completed frame, saturating
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, load=0, rom_addr=0, busy=0,
//   pending=0, grant=0, rr_ptr=0, drop_acc=0, frame_drops=0, vsync_q=0.
//   Reset mid-line abandons the line; nothing resumes before the next LOAD_START.
//  FSM states: IDLE, SETUP, LOAD.
//   IDLE: when hpos==LOAD_START, pending<=req.
//    If req!=0: grant<=pick(req,rr_ptr) and go to SETUP. Else stay in IDLE; no outputs.
//   SETUP: rom_addr=rom_addr_in[grant]; load=0. Always go to LOAD next cycle.
//   LOAD: rom_addr held; load[grant]=1 for exactly this cycle; pending[grant] cleared.
//    Let rest=pending with bit grant cleared.
//    If rest==0: go to IDLE.
//    Else if hpos+2 < LOAD_END: grant<=pick(rest,rr_ptr) and go to SETUP.
//    Else (window exhausted): drop_acc+=popcount(rest), rr_ptr<=pick(rest,rr_ptr),
//     and go to IDLE.
//  pick(mask,ptr): lowest index i>=ptr with mask[i]=1; if none, wraps from 0.
//   Only called with mask!=0.
//  rr_ptr changes only on a drop. Lines with no drop keep the order.
//  rom_addr is a combinational mux of registered grant. In IDLE it is
//   rom_addr_in[grant], so it is stable and glitch-free between lines.
//  Latency: first SETUP at hpos LOAD_START+1; k-th load strobe at LOAD_START+2k.
//  Frame accounting: vsync_q registers vsync. On a rising edge (vsync & ~vsync_q):
//   frame_drops<=drop_acc; drop_acc<=0.
//   If a drop occurs in the same cycle, it counts toward the new frame:
//   drop_acc<=popcount(rest).
//  Width: drop_acc and frame_drops saturate at 255; no wrap.
//  hpos==LOAD_START while not IDLE is ignored; the current sequence completes.
//   This is a parameter misconfiguration.
//  req is sampled only at the snapshot. Later changes affect the next line only.
// STRUCTURE
//  Shared package sprite_sched_pkg: state encoding (IDLE/SETUP/LOAD),
//   DROP_SAT=8'hFF, and a popcount function.
//  Sub-module sprite_rr_picker (mask, ptr -> index, valid): combinational
//   rotating priority encoder. Instantiated once, fed pending or rest.
//  Top contains the FSM, address mux, drop accumulator and vsync edge detect.
// TESTING
//  1 N=2, req=2'b11, yofs0=3, yofs1=9 at hpos=256 -> rom_addr=3 @257-258,
//    load=01 @258; rom_addr=9 @259-260, load=10 @260; IDLE/busy=0 @261.
//  2 req=0 at hpos 256 -> load stays 0 for the line; busy never rises.
//  3 N=4, LOAD_END=262, req=4'hF -> loads 0,1 at 258 and 260; 2 drops; rr_ptr=2.
//    Next line with req=4'hF -> loads 2,3; 2 more drops; rr_ptr=0.
//    vsync rise -> frame_drops=4.
//  4 Drop in the same cycle as vsync rising edge -> frame_drops excludes it.
//    Next frame's frame_drops includes it.
//  5 Force 300 drops in one frame -> frame_drops=255 (saturated), not 44.
//  6 Assert reset during LOAD of sprite 0 -> load=0 and rom_addr=0 immediately.
//    After release, no strobe until hpos==256; then normal sequence from sprite 0.

Source files
------------

// File: rtl/sprite_load_scheduler_pkg.sv
// Shared definitions for the sprite load scheduler.
//   state_e   : scheduler FSM states (IDLE / SETUP / LOAD)
//   DROP_SAT  : saturation value of the per-frame drop counters
//   popcount  : number of set bits in a request mask (up to 16 sprites)
//   sat_add   : drop-counter add that sticks at DROP_SAT instead of wrapping
package sprite_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD
  } state_e;

  localparam logic [7:0] DROP_SAT = 8'hFF;

  function automatic logic [4:0] popcount(input logic [15:0] mask);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(mask[i]);
    end
    return n;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] acc, input logic [4:0] inc);
    logic [8:0] sum;
    sum = {1'b0, acc} + {4'b0000, inc};
    return (sum > {1'b0, DROP_SAT}) ? DROP_SAT : sum[7:0];
  endfunction

endpackage

// File: rtl/sprite_load_scheduler_if.sv
// Bus between the scheduler and the sprite renderers sharing the bitmap ROM.
//   req         : renderer in_progress flags, one per sprite
//   rom_addr_in : renderer ROM row addresses, sprite i at [i*YOFS_BITS +: YOFS_BITS]
//   rom_addr    : shared ROM row address driven by the scheduler
//   load        : one-hot, single-cycle load strobes to the renderers
// master = scheduler side, slave = renderer side.
interface sprite_load_scheduler_if #(
  parameter int NUM_SPRITES = 2,
  parameter int YOFS_BITS   = 4
);
  logic [NUM_SPRITES-1:0]           req;
  logic [NUM_SPRITES*YOFS_BITS-1:0] rom_addr_in;
  logic [YOFS_BITS-1:0]             rom_addr;
  logic [NUM_SPRITES-1:0]           load;

  modport master (input req, rom_addr_in, output rom_addr, load);
  modport slave  (output req, rom_addr_in, input rom_addr, load);
endinterface

// File: rtl/sprite_rr_picker.sv
// Rotating priority encoder.
//   mask  : candidate sprites
//   ptr   : index with highest priority
//   index : lowest set index at or above ptr, wrapping to 0 when none is found
//   valid : mask has at least one bit set
module sprite_rr_picker #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] index,
  output logic          valid
);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    index = '0;
    valid = 1'b0;
    cand  = '0;
    for (int ofs = N - 1; ofs >= 0; ofs--) begin
      cand = IW'((int'(ptr) + ofs) % N);
      if (mask[cand]) begin
        index = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_load_scheduler.sv
// Shares one sprite bitmap ROM between NUM_SPRITES renderers during hblank.
// At hpos == LOAD_START the active renderers are snapshotted; each is then
// given a SETUP cycle (ROM address driven) and a LOAD cycle (strobe), in
// rotating-priority order. Requests that do not fit before LOAD_END are
// dropped, counted, and served first on the next line.
//   clk, reset  : pixel clock, asynchronous active-low reset
//   hpos, vsync : timing from the sync generator
//   bus         : request / address / strobe bus (master side)
//   busy        : high while in SETUP or LOAD
//   frame_drops : drops in the last completed frame, saturating at 255
module sprite_load_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int NUM_SPRITES = 2,
  parameter int YOFS_BITS   = 4,
  parameter int LOAD_START  = 256,
  parameter int LOAD_END    = 300
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8:0]              hpos,
  input  logic                    vsync,
  sprite_load_scheduler_if.master bus,
  output logic                    busy,
  output logic [7:0]              frame_drops
);

  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  state_e                 state, state_next;
  logic [IW-1:0]          grant, grant_next;
  logic [IW-1:0]          rr_ptr, rr_ptr_next;
  logic [NUM_SPRITES-1:0] pending, pending_next;
  logic [NUM_SPRITES-1:0] rest;
  logic [NUM_SPRITES-1:0] pick_mask;
  logic [IW-1:0]          pick_index;
  logic                   pick_valid;
  logic [NUM_SPRITES-1:0] load_vec;
  logic [4:0]             drop_now;
  logic [7:0]             drop_acc;
  logic                   vsync_q;
  logic                   vsync_rise;
  logic [YOFS_BITS-1:0]   rom_sel;

  // Requests still waiting once the current grant has been strobed.
  assign rest = pending & ~(NUM_SPRITES'(1) << grant);

  // One picker serves both the snapshot (IDLE) and the follow-on choice (LOAD).
  assign pick_mask = (state == ST_IDLE) ? bus.req : rest;

  sprite_rr_picker #(.N(NUM_SPRITES)) u_picker (
    .mask  (pick_mask),
    .ptr   (rr_ptr),
    .index (pick_index),
    .valid (pick_valid)
  );

  always_comb begin
    state_next   = state;
    grant_next   = grant;
    pending_next = pending;
    rr_ptr_next  = rr_ptr;
    load_vec     = '0;
    drop_now     = '0;
    busy         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hpos == 9'(LOAD_START)) begin
          pending_next = bus.req;
          if (pick_valid) begin
            grant_next = pick_index;
            state_next = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        busy       = 1'b1;
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        busy            = 1'b1;
        load_vec[grant] = 1'b1;
        pending_next    = rest;
        if (rest == '0) begin
          state_next = ST_IDLE;
        end else if (int'(hpos) + 2 < LOAD_END) begin
          grant_next = pick_index;
          state_next = ST_SETUP;
        end else begin
          // Window exhausted: the first unserved sprite leads next line.
          drop_now    = popcount(16'(rest));
          rr_ptr_next = pick_index;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!reset) begin
      state   <= ST_IDLE;
      grant   <= '0;
      pending <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_next;
      grant   <= grant_next;
      pending <= pending_next;
      rr_ptr  <= rr_ptr_next;
    end
  end

  // Frame accounting: a drop landing on the vsync edge belongs to the new frame.
  assign vsync_rise = vsync & ~vsync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q     <= 1'b0;
      drop_acc    <= '0;
      frame_drops <= '0;
    end else begin
      vsync_q <= vsync;
      if (vsync_rise) begin
        frame_drops <= drop_acc;
        drop_acc    <= sat_add(8'd0, drop_now);
      end else begin
        drop_acc <= sat_add(drop_acc, drop_now);
      end
    end
  end

  // Address follows the registered grant, so it only changes on clock edges;
  // it is forced to zero while reset is held.
  assign rom_sel      = YOFS_BITS'(bus.rom_addr_in >> (int'(grant) * YOFS_BITS));
  assign bus.rom_addr = reset ? rom_sel : '0;
  assign bus.load     = load_vec;

endmodule

// File: tb/tb_sprite_load_scheduler.sv
`timescale 1ns/1ps
// Two scheduler instances share hpos/vsync/reset:
//   g_inst[0]: 2 sprites, LOAD_END=300 (ample window)
//   g_inst[1]: 4 sprites, LOAD_END=262 (two loads per line, rest dropped)
// Each instance has a line-level model: at the snapshot it lays out the whole
// cycle-by-cycle schedule in a queue; a compare process checks every cycle.
module tb_sprite_load_scheduler;

  typedef struct {
    logic [3:0] load;
    int         grant;
    bit         busy;
    int         drops;
  } entry_t;

  logic        clk;
  logic        reset;
  logic [8:0]  hpos;
  logic        vsync;
  logic [3:0]  req_v [2];
  logic [15:0] yofs_v [2];
  bit          chk_en;
  int          total;
  int          bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (hpos=%0d, t=%0t)", name, act, exp, hpos, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int N = (g == 0) ? 2 : 4;
    localparam int E = (g == 0) ? 300 : 262;

    logic       busy;
    logic [7:0] frame_drops;

    sprite_load_scheduler_if #(.NUM_SPRITES(N), .YOFS_BITS(4)) bus ();
    assign bus.req         = req_v[g][N-1:0];
    assign bus.rom_addr_in = yofs_v[g][N*4-1:0];

    sprite_load_scheduler #(
      .NUM_SPRITES(N), .YOFS_BITS(4), .LOAD_START(256), .LOAD_END(E)
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .hpos        (hpos),
      .vsync       (vsync),
      .bus         (bus),
      .busy        (busy),
      .frame_drops (frame_drops)
    );

    // ---- model ----
    entry_t q[$];
    entry_t cur;
    int     order[$];
    int     m_rr, m_acc, m_fd, slots, served;
    bit     m_vq;
    logic [3:0] rv;

    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        q.delete();
        cur   = '{load: 4'd0, grant: 0, busy: 1'b0, drops: 0};
        m_rr  = 0;
        m_acc = 0;
        m_fd  = 0;
        m_vq  = 1'b0;
      end else begin
        // drops belonging to the cycle that ends at this edge
        if (vsync && !m_vq) begin
          m_fd  = m_acc;
          m_acc = (cur.drops > 255) ? 255 : cur.drops;
        end else begin
          m_acc = (m_acc + cur.drops > 255) ? 255 : m_acc + cur.drops;
        end
        m_vq = vsync;

        if (q.size() > 0) begin
          cur = q.pop_front();
        end else if (!cur.busy && hpos == 9'd256 && req_v[g][N-1:0] != 0) begin
          rv = req_v[g];
          order.delete();
          for (int ofs = 0; ofs < N; ofs++) begin
            if (((rv >> ((m_rr + ofs) % N)) & 4'd1) != 4'd0) order.push_back((m_rr + ofs) % N);
          end
          // strobe k lands at 256+2k; the first always happens
          slots  = (E - 256 - 1) / 2;
          if (slots < 1) slots = 1;
          served = (order.size() < slots) ? order.size() : slots;
          for (int k = 0; k < served; k++) begin
            q.push_back('{load: 4'd0, grant: order[k], busy: 1'b1, drops: 0});
            q.push_back('{load: 4'(4'd1 << order[k]), grant: order[k], busy: 1'b1,
                          drops: (k == served - 1) ? order.size() - served : 0});
          end
          if (order.size() > served) m_rr = order[served];
          cur = q.pop_front();
        end else begin
          cur = '{load: 4'd0, grant: cur.grant, busy: 1'b0, drops: 0};
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("g%0d load", g), 32'(bus.load), 32'(cur.load[N-1:0]));
        check($sformatf("g%0d busy", g), 32'(busy), 32'(cur.busy));
        check($sformatf("g%0d rom_addr", g), 32'(bus.rom_addr),
              reset ? 32'(4'(yofs_v[g] >> (cur.grant * 4))) : 32'd0);
        check($sformatf("g%0d frame_drops", g), 32'(frame_drops), 32'(m_fd));
      end
    end
  end

  task automatic step(input int h);
    @(posedge clk);
    #1;
    hpos = 9'(h);
  endtask

  // One short line: hpos 250..266; vsync high from hpos vs_from (never if < 0).
  task automatic line(input int vs_from);
    for (int h = 250; h <= 266; h++) begin
      step(h);
      vsync = (vs_from >= 0) && (h >= vs_from);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad = 0;
    chk_en = 1'b0;
    reset = 1'b0;
    hpos = 9'd0;
    vsync = 1'b0;
    req_v[0] = 4'd0;
    req_v[1] = 4'd0;
    yofs_v[0] = 16'h0093;   // sprite0 row 3, sprite1 row 9
    yofs_v[1] = 16'h4321;   // sprites 0..3 rows 1..4
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // reset state
    check("rst g0 load", 32'(g_inst[0].bus.load), 32'd0);
    check("rst g0 rom_addr", 32'(g_inst[0].bus.rom_addr), 32'd0);
    check("rst g1 busy", 32'(g_inst[1].busy), 32'd0);
    check("rst g1 frame_drops", 32'(g_inst[1].frame_drops), 32'd0);
    step(200);
    #1 reset = 1'b1;

    // both instances full request; g1 drops sprites 2,3
    req_v[0] = 4'b0011;
    req_v[1] = 4'hF;
    for (int h = 250; h <= 266; h++) begin
      step(h);
      case (h)
        257: begin
          check("t1 g0 rom_addr@257", 32'(g_inst[0].bus.rom_addr), 32'd3);
          check("t1 g0 busy@257", 32'(g_inst[0].busy), 32'd1);
        end
        258: begin
          check("t1 g0 load@258", 32'(g_inst[0].bus.load), 32'b01);
          check("t1 g0 rom_addr@258", 32'(g_inst[0].bus.rom_addr), 32'd3);
          check("t3 g1 load@258", 32'(g_inst[1].bus.load), 32'b0001);
        end
        259: check("t1 g0 rom_addr@259", 32'(g_inst[0].bus.rom_addr), 32'd9);
        260: begin
          check("t1 g0 load@260", 32'(g_inst[0].bus.load), 32'b10);
          check("t3 g1 load@260", 32'(g_inst[1].bus.load), 32'b0010);
        end
        261: begin
          check("t1 g0 busy@261", 32'(g_inst[0].busy), 32'd0);
          check("t1 g0 rom_addr@261", 32'(g_inst[0].bus.rom_addr), 32'd9);
          check("t3 g1 busy@261", 32'(g_inst[1].busy), 32'd0);
        end
        default: ;
      endcase
    end

    // g0 no request; g1 resumes at sprite 2, drops 0,1; vsync rises at 264
    req_v[0] = 4'd0;
    for (int h = 250; h <= 266; h++) begin
      step(h);
      vsync = (h >= 264);
      case (h)
        257: check("t2 g0 busy@257", 32'(g_inst[0].busy), 32'd0);
        258: begin
          check("t2 g0 load@258", 32'(g_inst[0].bus.load), 32'd0);
          check("t3 g1 load@258", 32'(g_inst[1].bus.load), 32'b0100);
          check("t3 g1 rom_addr@258", 32'(g_inst[1].bus.rom_addr), 32'd3);
        end
        260: check("t3 g1 load@260", 32'(g_inst[1].bus.load), 32'b1000);
        default: ;
      endcase
    end
    check("t3 g1 frame_drops", 32'(g_inst[1].frame_drops), 32'd4);
    check("t2 g0 frame_drops", 32'(g_inst[0].frame_drops), 32'd0);

    // drop on the same edge as vsync rise -> counted in the next frame
    line(260);
    check("t4 g1 frame_drops same edge", 32'(g_inst[1].frame_drops), 32'd0);
    req_v[1] = 4'd0;
    line(-1);
    line(250);
    check("t4 g1 frame_drops next frame", 32'(g_inst[1].frame_drops), 32'd2);

    // 300 drops in one frame saturate at 255
    req_v[0] = 4'b0011;
    req_v[1] = 4'hF;
    repeat (150) line(-1);
    req_v[1] = 4'd0;
    line(250);
    check("t5 g1 frame_drops saturated", 32'(g_inst[1].frame_drops), 32'd255);
    check("t5 g0 frame_drops", 32'(g_inst[0].frame_drops), 32'd0);

    // reset during LOAD of the first sprite
    req_v[1] = 4'hF;
    for (int h = 250; h <= 258; h++) step(h);
    reset = 1'b0;
    #1;
    check("t6 g0 load in reset", 32'(g_inst[0].bus.load), 32'd0);
    check("t6 g0 rom_addr in reset", 32'(g_inst[0].bus.rom_addr), 32'd0);
    check("t6 g1 load in reset", 32'(g_inst[1].bus.load), 32'd0);
    check("t6 g1 rom_addr in reset", 32'(g_inst[1].bus.rom_addr), 32'd0);
    step(259);
    step(260);
    #1 reset = 1'b1;
    for (int h = 261; h <= 266; h++) step(h);
    check("t6 g0 busy after release", 32'(g_inst[0].busy), 32'd0);
    check("t6 g1 busy after release", 32'(g_inst[1].busy), 32'd0);
    for (int h = 250; h <= 266; h++) begin
      step(h);
      if (h == 258) begin
        check("t6 g0 load@258 after reset", 32'(g_inst[0].bus.load), 32'b01);
        check("t6 g1 load@258 after reset", 32'(g_inst[1].bus.load), 32'b0001);
        check("t6 g1 rom_addr@258 after reset", 32'(g_inst[1].bus.rom_addr), 32'd1);
      end
    end

    step(0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
